i2c_arbiter: RTL

- Shares one i2c_master instance between NUM_REQ independent requesters (sensor pollers, config loaders, and similar).
- Uses round-robin arbitration and latches the winning requester's address, payload and size.
- Issues a single start to the master and watches its valid_trans, valid_recep and error outputs.
- Returns a per-requester completion pulse with status and the last received byte.
- Sits between the system request fabric and i2c_master.

---
 rtl/i2c_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin front end that shares one i2c_master among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to build the WAIT-state watchdog (limit TIMEOUT_CYCLES).
module i2c_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*8-1:0]  req_addr,
    input  logic [NUM_REQ*72-1:0] req_data,
    input  logic [NUM_REQ*8-1:0]  req_size,
    input  logic [15:0]           cfg_prescaler,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [7:0]            rsp_data,
    output logic                  busy,
    output logic                  mst_start,
    output logic [7:0]            mst_addr,
    output logic [71:0]           mst_data,
    output logic [7:0]            mst_size,
    output logic [15:0]           mst_prescaler,
    input  logic                  mst_valid_trans,
    input  logic                  mst_valid_recep,
    input  logic [7:0]            mst_data_received,
    input  logic                  mst_error
);

    localparam int              ID_W      = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FINISH
    } state_t;

    state_t state, next_state;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    sel_id;
    logic               sel_valid;
    logic [ID_W:0]      scan_idx;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [NUM_REQ-1:0] id_onehot;
    logic               size_bad;
    logic               trans_prev;
    logic               recep_prev;
    logic               trans_rise;
    logic               recep_rise;
    logic               enter_finish;
    logic               fin_err;

    logic [7:0]  addr_arr [NUM_REQ];
    logic [71:0] data_arr [NUM_REQ];
    logic [7:0]  size_arr [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign addr_arr[g] = req_addr[8*g +: 8];
            assign data_arr[g] = req_data[72*g +: 72];
            assign size_arr[g] = req_size[8*g +: 8];
        end
    endgenerate

    // Scan downward so the candidate closest above rr_ptr is the last one kept.
    always_comb begin
        sel_id    = '0;
        sel_valid = 1'b0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (req[scan_idx[ID_W-1:0]]) begin
                sel_id    = scan_idx[ID_W-1:0];
                sel_valid = 1'b1;
            end
        end
    end

    assign sel_onehot = NUM_REQ'(1) << sel_id;
    assign id_onehot  = NUM_REQ'(1) << id_q;
    assign size_bad   = (size_arr[sel_id] == 8'd0) || (size_arr[sel_id] > 8'd9);
    assign trans_rise = mst_valid_trans & ~trans_prev;
    assign recep_rise = mst_valid_recep & ~recep_prev;
    assign busy       = (state != IDLE);

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wait_cnt;
    logic        timeout_hit;
    logic        fin_timeout;
    logic        rsp_timeout_q;

    assign timeout_hit = (state == WAIT) && (wait_cnt == TIMEOUT_LAST);
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt      <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (enter_finish) begin
                rsp_timeout_q <= fin_timeout;
            end
        end
    end
`else
    assign rsp_timeout = 1'b0;

    // The watchdog limit has no effect when the watchdog is not built.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Master error outranks completion, which outranks the watchdog.
    always_comb begin
        next_state   = state;
        enter_finish = 1'b0;
        fin_err      = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        fin_timeout  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    if (size_bad) begin
                        next_state   = FINISH;
                        enter_finish = 1'b1;
                        fin_err      = 1'b1;
                    end else begin
                        next_state = LAUNCH;
                    end
                end
            end
            LAUNCH: next_state = WAIT;
            WAIT: begin
                if (mst_error) begin
                    next_state   = FINISH;
                    enter_finish = 1'b1;
                    fin_err      = 1'b1;
                end else if (trans_rise) begin
                    next_state   = FINISH;
                    enter_finish = 1'b1;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    next_state   = FINISH;
                    enter_finish = 1'b1;
                    fin_err      = 1'b1;
                    fin_timeout  = 1'b1;
                end
`endif
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // done is raised on the edge entering FINISH so it is high during FINISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt           <= '0;
            done          <= '0;
            rsp_err       <= 1'b0;
            rsp_data      <= '0;
            mst_start     <= 1'b0;
            mst_addr      <= '0;
            mst_data      <= '0;
            mst_size      <= '0;
            mst_prescaler <= '0;
            id_q          <= '0;
            rr_ptr        <= '0;
            trans_prev    <= 1'b0;
            recep_prev    <= 1'b0;
        end else begin
            trans_prev <= mst_valid_trans;
            recep_prev <= mst_valid_recep;
            gnt        <= '0;
            done       <= '0;
            mst_start  <= (state == LAUNCH);

            if (state == IDLE && sel_valid) begin
                id_q          <= sel_id;
                gnt           <= sel_onehot;
                mst_addr      <= addr_arr[sel_id];
                mst_data      <= data_arr[sel_id];
                mst_size      <= size_arr[sel_id];
                mst_prescaler <= cfg_prescaler;
                rsp_data      <= '0;
            end

            if (state == WAIT && recep_rise) begin
                rsp_data <= mst_data_received;
            end

            if (enter_finish) begin
                done    <= (state == IDLE) ? sel_onehot : id_onehot;
                rsp_err <= fin_err;
            end

            if (state == FINISH) begin
                rr_ptr <= (id_q == LAST_ID) ? '0 : id_q + 1'b1;
            end
        end
    end

endmodule
